// File: rtl/i2c_slave_fsm.sv
// I2C responder: START/STOP detection, fixed-address match, two-byte write capture and
// two-byte read return on an open-drain sda line.
module i2c_slave_fsm #(
    parameter int unsigned         ADDR_LEN    = 7,
    parameter int unsigned         DATA_LEN    = 8,
    parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = ADDR_LEN'(7'h2A),
    parameter int unsigned         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    inout  wire                 sda,
    input  logic [DATA_LEN-1:0] rd_data_1,
    input  logic [DATA_LEN-1:0] rd_data_2,
    output logic [DATA_LEN-1:0] wr_data_1,
    output logic [DATA_LEN-1:0] wr_data_2,
    output logic                wr_valid,
    output logic                busy
);
    localparam int unsigned MAX_BITS = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
    localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    state_t                state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                  scl_s, sda_s, scl_d, sda_d;
    logic                  scl_rise, scl_fall, start_det, stop_det;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [1:0]            byte_idx, byte_idx_nxt;
    logic [ADDR_LEN-1:0]   addr_sh, addr_sh_nxt;
    logic                  rw, rw_nxt;
    logic [DATA_LEN-1:0]   dsh, dsh_nxt;
    logic [DATA_LEN-1:0]   rd_sel;
    logic                  sda_low, sda_low_nxt;
    logic [DATA_LEN-1:0]   wr_data_1_nxt, wr_data_2_nxt;
    logic                  wr_valid_nxt, busy_nxt;

    // Input synchronizers plus one history flop; idle-high reset avoids phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;
    assign rd_sel    = (byte_idx == 2'd0) ? rd_data_1 : rd_data_2;
    assign sda       = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            addr_sh   <= '0;
            rw        <= 1'b0;
            dsh       <= '0;
            sda_low   <= 1'b0;
            wr_data_1 <= '0;
            wr_data_2 <= '0;
            wr_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_idx  <= byte_idx_nxt;
            addr_sh   <= addr_sh_nxt;
            rw        <= rw_nxt;
            dsh       <= dsh_nxt;
            sda_low   <= sda_low_nxt;
            wr_data_1 <= wr_data_1_nxt;
            wr_data_2 <= wr_data_2_nxt;
            wr_valid  <= wr_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next state: STOP beats START beats per-state progress; ACK phases use sda_low as sub-phase.
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:
                    if (scl_rise && bit_cnt == CNT_W'(ADDR_LEN))
                        state_nxt = (addr_sh == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:
                    if (scl_fall && sda_low) state_nxt = rw ? RD_BYTE : WR_BYTE;
                WR_BYTE:
                    if (scl_rise && bit_cnt == CNT_W'(DATA_LEN - 1))
                        state_nxt = (byte_idx >= 2'd2) ? WAIT_STOP : WR_ACK;
                WR_ACK:
                    if (scl_fall && sda_low) state_nxt = WR_BYTE;
                RD_BYTE:
                    if (scl_fall && bit_cnt == CNT_W'(DATA_LEN)) state_nxt = RD_ACK;
                RD_ACK:
                    if (scl_rise) state_nxt = sda_s ? WAIT_STOP : RD_BYTE;
                default: ;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        byte_idx_nxt  = byte_idx;
        addr_sh_nxt   = addr_sh;
        rw_nxt        = rw;
        dsh_nxt       = dsh;
        sda_low_nxt   = sda_low;
        wr_data_1_nxt = wr_data_1;
        wr_data_2_nxt = wr_data_2;
        wr_valid_nxt  = 1'b0;
        busy_nxt      = busy;
        if (stop_det || start_det) begin
            sda_low_nxt  = 1'b0;
            busy_nxt     = start_det & ~stop_det;
            bit_cnt_nxt  = '0;
            byte_idx_nxt = '0;
        end else begin
            case (state)
                ADDR:
                    if (scl_rise) begin
                        if (bit_cnt == CNT_W'(ADDR_LEN)) begin
                            rw_nxt      = sda_s;
                            bit_cnt_nxt = '0;
                        end else begin
                            addr_sh_nxt = {addr_sh[ADDR_LEN-2:0], sda_s};
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                ADDR_ACK:
                    if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low_nxt = 1'b1;
                        end else if (rw) begin
                            sda_low_nxt = ~rd_sel[DATA_LEN-1];
                            dsh_nxt     = {rd_sel[DATA_LEN-2:0], 1'b0};
                            bit_cnt_nxt = CNT_W'(1);
                        end else begin
                            sda_low_nxt = 1'b0;
                        end
                    end
                WR_BYTE:
                    if (scl_rise) begin
                        dsh_nxt     = {dsh[DATA_LEN-2:0], sda_s};
                        bit_cnt_nxt = (bit_cnt == CNT_W'(DATA_LEN - 1)) ? '0 : bit_cnt + CNT_W'(1);
                    end
                WR_ACK:
                    if (scl_fall) begin
                        if (!sda_low) begin
                            sda_low_nxt = 1'b1;
                            if (byte_idx == 2'd0) begin
                                wr_data_1_nxt = dsh;
                            end else begin
                                wr_data_2_nxt = dsh;
                                wr_valid_nxt  = 1'b1;
                            end
                        end else begin
                            sda_low_nxt  = 1'b0;
                            byte_idx_nxt = byte_idx + 2'd1;
                        end
                    end
                RD_BYTE:
                    if (scl_fall) begin
                        if (bit_cnt == CNT_W'(DATA_LEN)) begin
                            sda_low_nxt = 1'b0;
                            bit_cnt_nxt = '0;
                        end else if (bit_cnt == '0) begin
                            sda_low_nxt = ~rd_sel[DATA_LEN-1];
                            dsh_nxt     = {rd_sel[DATA_LEN-2:0], 1'b0};
                            bit_cnt_nxt = CNT_W'(1);
                        end else begin
                            sda_low_nxt = ~dsh[DATA_LEN-1];
                            dsh_nxt     = {dsh[DATA_LEN-2:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                RD_ACK:
                    if (scl_rise && !sda_s) byte_idx_nxt = (byte_idx == 2'd0) ? 2'd1 : 2'd0;
                default:
                    sda_low_nxt = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: a bit-level bus master plus a transaction-level expectation model.
module tb_i2c_slave_fsm;
    localparam logic [6:0] DEV_ADDR = 7'h2A;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] rd_data_1 = 8'h00;
    logic [7:0] rd_data_2 = 8'h00;
    logic [7:0] wr_data_1, wr_data_2;
    logic       wr_valid, busy;
    tri1        sda;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    int low_seen = 0;
    logic [7:0] exp_wr1 = 8'h00;
    logic [7:0] exp_wr2 = 8'h00;

    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_fsm dut (
        .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .wr_data_1(wr_data_1), .wr_data_2(wr_data_2),
        .wr_valid(wr_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_valid === 1'b1) valid_cnt++;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One scl period: data set mid-low, sampled late in the high phase.
    task automatic send_bit(input logic b, output logic bus);
        wait_clk(4); m_low = ~b;
        wait_clk(4); scl_m = 1'b1;
        wait_clk(6); bus = sda;
        if (b && bus !== 1'b1) low_seen++;
        wait_clk(2); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        wait_clk(4); m_low = 1'b1;
        wait_clk(8); scl_m = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(4); m_low = 1'b0;
        wait_clk(4); scl_m = 1'b1;
        wait_clk(8); m_low = 1'b1;
        wait_clk(8); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(4); m_low = 1'b1;
        wait_clk(4); scl_m = 1'b1;
        wait_clk(8); m_low = 1'b0;
        wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic bus;
        for (int i = 7; i >= 0; i--) send_bit(d[i], bus);
        send_bit(1'b1, bus);
        ack = (bus === 1'b0);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic bus;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, bus);
            d[i] = bus;
        end
        send_bit(~mack, bus);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl_m = 1'b1; m_low = 1'b0;
        wait_clk(3);
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b expected 1", sda); end
        vectors++; if (wr_data_1 !== 8'h00 || wr_data_2 !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data: got %h/%h expected 00/00", wr_data_1, wr_data_2); end
        vectors++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got valid=%b busy=%b expected 0/0", wr_valid, busy); end
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_write();
        logic ack; int v0;
        v0 = valid_cnt;
        bus_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy_start: got %b expected 1", busy); end
        write_byte({DEV_ADDR, 1'b0}, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL write_addr_ack: got %b expected 1", ack); end
        write_byte(8'hA5, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL write_b0_ack: got %b expected 1", ack); end
        write_byte(8'h3C, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL write_b1_ack: got %b expected 1", ack); end
        bus_stop();
        exp_wr1 = 8'hA5; exp_wr2 = 8'h3C;
        vectors++; if (wr_data_1 !== exp_wr1 || wr_data_2 !== exp_wr2) begin miscompares++; $display("FAIL write_data: got %h/%h expected %h/%h", wr_data_1, wr_data_2, exp_wr1, exp_wr2); end
        vectors++; if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL write_valid_pulses: got %0d expected 1", valid_cnt - v0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_mismatch();
        logic ack; int v0, l0;
        v0 = valid_cnt; l0 = low_seen;
        bus_start();
        write_byte({7'h15, 1'b0}, ack);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL mismatch_addr_ack: got %b expected 0", ack); end
        write_byte(8'hFF, ack);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL mismatch_data_ack: got %b expected 0", ack); end
        bus_stop();
        vectors++; if (low_seen != l0) begin miscompares++; $display("FAIL mismatch_sda_driven: got %0d low samples expected 0", low_seen - l0); end
        vectors++; if (wr_data_1 !== exp_wr1 || wr_data_2 !== exp_wr2) begin miscompares++; $display("FAIL mismatch_wr_data: got %h/%h expected %h/%h", wr_data_1, wr_data_2, exp_wr1, exp_wr2); end
        vectors++; if (valid_cnt != v0) begin miscompares++; $display("FAIL mismatch_valid: got %0d pulses expected 0", valid_cnt - v0); end
    endtask

    task automatic test_read();
        logic ack; logic [7:0] got;
        rd_data_1 = 8'h5A; rd_data_2 = 8'hC3;
        bus_start();
        write_byte({DEV_ADDR, 1'b1}, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
        read_byte(1'b1, got);
        vectors++; if (got !== 8'h5A) begin miscompares++; $display("FAIL read_byte0: got %h expected 5a", got); end
        read_byte(1'b0, got);
        vectors++; if (got !== 8'hC3) begin miscompares++; $display("FAIL read_byte1: got %h expected c3", got); end
        wait_clk(4);
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL read_release_after_nack: got %b expected 1", sda); end
        bus_stop();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_overrun();
        logic ack; int v0;
        v0 = valid_cnt;
        bus_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        write_byte(8'h11, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL overrun_b0_ack: got %b expected 1", ack); end
        write_byte(8'h22, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL overrun_b1_ack: got %b expected 1", ack); end
        write_byte(8'h33, ack);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL overrun_b2_nack: got %b expected 0", ack); end
        bus_stop();
        exp_wr1 = 8'h11; exp_wr2 = 8'h22;
        vectors++; if (wr_data_1 !== exp_wr1 || wr_data_2 !== exp_wr2) begin miscompares++; $display("FAIL overrun_data: got %h/%h expected 11/22", wr_data_1, wr_data_2); end
        vectors++; if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL overrun_valid: got %0d expected 1", valid_cnt - v0); end
    endtask

    task automatic test_repeated_start();
        logic ack; logic [7:0] got; int v0;
        v0 = valid_cnt;
        rd_data_1 = 8'h96; rd_data_2 = 8'h69;
        bus_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        write_byte(8'h77, ack);
        exp_wr1 = 8'h77;
        bus_rstart();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstart_busy: got %b expected 1", busy); end
        write_byte({DEV_ADDR, 1'b1}, ack);
        vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL rstart_addr_ack: got %b expected 1", ack); end
        read_byte(1'b0, got);
        vectors++; if (got !== 8'h96) begin miscompares++; $display("FAIL rstart_read: got %h expected 96", got); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstart_busy_before_stop: got %b expected 1", busy); end
        bus_stop();
        vectors++; if (wr_data_1 !== exp_wr1 || wr_data_2 !== exp_wr2) begin miscompares++; $display("FAIL rstart_wr_data: got %h/%h expected %h/%h", wr_data_1, wr_data_2, exp_wr1, exp_wr2); end
        vectors++; if (valid_cnt != v0) begin miscompares++; $display("FAIL rstart_valid: got %0d expected 0", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid_op();
        logic bus; logic [7:0] a;
        a = {DEV_ADDR, 1'b0};
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i], bus);
        wait_clk(4); m_low = 1'b0;
        wait_clk(2);
        vectors++; if (sda !== 1'b0) begin miscompares++; $display("FAIL midop_ack_drive: got %b expected 0", sda); end
        rst_n = 1'b0; scl_m = 1'b1;
        #1;
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL midop_reset_sda: got %b expected 1", sda); end
        vectors++; if (wr_data_1 !== 8'h00 || wr_data_2 !== 8'h00 || busy !== 1'b0 || wr_valid !== 1'b0) begin
            miscompares++; $display("FAIL midop_reset_outputs: got %h/%h busy=%b valid=%b expected 00/00 0 0", wr_data_1, wr_data_2, busy, wr_valid); end
        exp_wr1 = 8'h00; exp_wr2 = 8'h00;
        wait_clk(3); rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_stop_mid_byte();
        logic ack, bus; int v0;
        v0 = valid_cnt;
        bus_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        write_byte(8'h5C, ack);
        exp_wr1 = 8'h5C;
        send_bit(1'b1, bus); send_bit(1'b1, bus); send_bit(1'b1, bus); send_bit(1'b0, bus);
        bus_stop();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stopmid_busy: got %b expected 0", busy); end
        vectors++; if (wr_data_1 !== exp_wr1 || wr_data_2 !== exp_wr2) begin miscompares++; $display("FAIL stopmid_data: got %h/%h expected %h/%h", wr_data_1, wr_data_2, exp_wr1, exp_wr2); end
        vectors++; if (valid_cnt != v0) begin miscompares++; $display("FAIL stopmid_valid: got %0d expected 0", valid_cnt - v0); end
    endtask

    // Random transactions; expectations come from the transaction-level rules.
    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            logic [6:0] a; logic rw, ack, match; int n, v0, exp_pulses;
            logic [7:0] d, got, r1, r2, exp_b;
            a  = ($urandom_range(0, 1) == 1) ? DEV_ADDR : 7'($urandom);
            rw = 1'($urandom);
            n  = $urandom_range(1, 3);
            r1 = 8'($urandom); r2 = 8'($urandom);
            rd_data_1 = r1; rd_data_2 = r2;
            match = (a == DEV_ADDR);
            v0 = valid_cnt;
            bus_start();
            write_byte({a, rw}, ack);
            vectors++; if (ack !== match) begin miscompares++; $display("FAIL rand%0d_addr_ack: got %b expected %b", t, ack, match); end
            for (int i = 0; i < n; i++) begin
                if (!rw) begin
                    d = 8'($urandom);
                    write_byte(d, ack);
                    vectors++; if (ack !== (match && i < 2)) begin miscompares++; $display("FAIL rand%0d_wr_ack%0d: got %b expected %b", t, i, ack, match && i < 2); end
                    if (match && i == 0) exp_wr1 = d;
                    if (match && i == 1) exp_wr2 = d;
                end else begin
                    read_byte(i != n - 1, got);
                    exp_b = !match ? 8'hFF : ((i % 2 == 0) ? r1 : r2);
                    vectors++; if (got !== exp_b) begin miscompares++; $display("FAIL rand%0d_rd%0d: got %h expected %h", t, i, got, exp_b); end
                end
            end
            bus_stop();
            exp_pulses = (match && !rw && n >= 2) ? 1 : 0;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand%0d_busy: got %b expected 0", t, busy); end
            vectors++; if (wr_data_1 !== exp_wr1 || wr_data_2 !== exp_wr2) begin miscompares++; $display("FAIL rand%0d_wr_data: got %h/%h expected %h/%h", t, wr_data_1, wr_data_2, exp_wr1, exp_wr2); end
            vectors++; if (valid_cnt - v0 != exp_pulses) begin miscompares++; $display("FAIL rand%0d_valid: got %0d expected %0d", t, valid_cnt - v0, exp_pulses); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_overrun();
        test_repeated_start();
        test_reset_mid_op();
        test_stop_mid_byte();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
